ram_dp_param: RTL
=================

RAM_DP_PARAM -- requirements
Module: ram_dp_param

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_W, 10, word width in bits.
- ADDR_W, 8, address width in bits.
- DEPTH, 256, number of words; legal range 2..2**ADDR_W.
- RD_MODE, 0, collision policy: 0 = read-first (old data), 1 = write-through (new data).
- OUT_REG, 0, extra output pipeline register: 0 = read latency 1, 1 = read latency 2.
REQ-002 Ports (name, direction, width, meaning), one per line:
- Clk, in, 1, single clock; all state updates on its rising edge.
- Rst, in, 1, reset; synchronous, active-high.
- En, in, 1, global enable; gates both write and read acceptance.
- We, in, 1, write strobe.
- WAddr, in, ADDR_W, write address.
- Din, in, DATA_W, write data.
- Re, in, 1, read strobe.
- RAddr, in, ADDR_W, read address.
- ClrReq, in, 1, one-cycle request to zero the whole array.
- Dout, out, DATA_W, read data.
- DoutValid, out, 1, one-cycle pulse marking Dout as valid.
- Busy, out, 1, high while the array is being cleared; all requests are ignored while high.

Function
REQ-003 The array SHALL have DEPTH words of DATA_W bits each, with one write port and one read port sharing Clk.
REQ-004 A write SHALL occur at the edge where En=1, We=1, Busy=0 and WAddr<DEPTH; otherwise the array is unchanged.
REQ-005 A read SHALL be accepted at the edge where En=1, Re=1, Busy=0 and RAddr<DEPTH.
REQ-006 Read timing for an accepted read at edge N:
- OUT_REG=0: Dout and DoutValid=1 appear after edge N.
- OUT_REG=1: Dout and DoutValid=1 appear after edge N+1.
REQ-007 DoutValid SHALL be high for exactly one cycle per accepted read; back-to-back reads give a DoutValid pulse every cycle.
REQ-008 Dout SHALL hold its last value when no read completes.
REQ-009 Out-of-range address (>=DEPTH): the write SHALL be dropped; the read SHALL be accepted and return 0 with DoutValid=1.
REQ-010 Same-edge write and read to the same address: RD_MODE=0 returns the pre-write word; RD_MODE=1 returns Din.
REQ-011 The FSM SHALL have the states CLEAR and READY:
- CLEAR: Busy=1; writes 0 to word ClrPtr each cycle, then ClrPtr+1; at ClrPtr=DEPTH-1 it writes that word and goes to READY.
- READY: Busy=0; at En=1, ClrReq=1 it goes to CLEAR with ClrPtr=0.
REQ-012 A CLEAR pass SHALL take exactly DEPTH cycles, and Busy SHALL fall on the edge after the last word is written.
REQ-013 A read already in flight in the OUT_REG pipeline when CLEAR starts SHALL still complete, with its DoutValid pulse.
REQ-014 ClrReq together with We/Re at the same edge in READY: the clear SHALL take priority; the write and read are discarded.
REQ-015 ClrReq during CLEAR SHALL be ignored; the sweep does not restart.

Reset
REQ-016 While Rst=1 at an edge: state=CLEAR, ClrPtr=0, Dout=0, DoutValid=0, Busy=1, and the output pipeline register is cleared.
REQ-017 After Rst is released, the sweep SHALL run and Busy SHALL fall DEPTH cycles later; every word reads 0 after that.
REQ-018 Rst asserted mid-sweep or mid-read SHALL restart the sweep at ClrPtr=0 and drop the pending read, with no DoutValid pulse.

Verification
REQ-019 Reset release with defaults -> Busy=1 for 256 cycles, then 0; a read of address 0 and a read of address 255 each return 0.
REQ-020 Write Addr 2 = 40, Addr 90 = 60, then read 2, then read 90 (OUT_REG=0) -> Dout=40 one cycle after the first read and 60 one cycle after the second, each with a 1-cycle DoutValid; repeat with OUT_REG=1 -> each result one cycle later.
REQ-021 Address 120 holds 128; same-edge write of 200 and read at 120 -> RD_MODE=0 gives 128 and RD_MODE=1 gives 200; a following read gives 200 in both modes.
REQ-022 En=0 with We=1, WAddr=5, Din=77 -> a later read of 5 returns its prior value, and no DoutValid pulse occurs while En=0.
REQ-023 Address 7 holds 33; ClrReq and a write of 99 to address 7 at the same edge -> Busy=1 for 256 cycles and the write is discarded; a read of 7 afterwards returns 0; ClrReq during the sweep does not extend Busy.
REQ-024 Rst pulsed at sweep cycle 100 -> Busy stays high for a further 256 cycles after release; Dout=0 and DoutValid=0 throughout.

Source files
------------

// File: rtl/ram_dp_param_if.sv
// rtl/ram_dp_param_if.sv - request/response bundle for the dual-port RAM with clear sweep
interface ram_dp_param_if #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 8
);
  logic              En;
  logic              We;
  logic [ADDR_W-1:0] WAddr;
  logic [DATA_W-1:0] Din;
  logic              Re;
  logic [ADDR_W-1:0] RAddr;
  logic              ClrReq;
  logic [DATA_W-1:0] Dout;
  logic              DoutValid;
  logic              Busy;

  modport master (
    output En, We, WAddr, Din, Re, RAddr, ClrReq,
    input  Dout, DoutValid, Busy
  );

  modport slave (
    input  En, We, WAddr, Din, Re, RAddr, ClrReq,
    output Dout, DoutValid, Busy
  );
endinterface

// File: rtl/ram_dp_param.sv
// rtl/ram_dp_param.sv - simple dual-port RAM with selectable collision policy,
// optional output register and a full-array clear sweep
module ram_dp_param #(
  parameter int DATA_W  = 10,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int RD_MODE = 0,
  parameter int OUT_REG = 0
) (
  input  logic               Clk,
  input  logic               Rst,
  ram_dp_param_if.slave      bus
);
  localparam logic [0:0]        ST_CLEAR = 1'b0;
  localparam logic [0:0]        ST_READY = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              s1_vld_q, s1_vld_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              dout_vld_q, dout_vld_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_acc;
  logic              wr_in_range;
  logic              rd_in_range;
  logic              collide;
  logic [DATA_W-1:0] rd_word;

  assign wr_in_range = {1'b0, bus.WAddr} < DEPTH_X;
  assign rd_in_range = {1'b0, bus.RAddr} < DEPTH_X;

  // The clear request wins over any same-edge write or read.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    mem_we    = 1'b0;
    mem_waddr = bus.WAddr;
    mem_wdata = bus.Din;
    rd_acc    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        if (clr_ptr_q == LAST_PTR) begin
          state_d = ST_READY;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      default: begin
        if (bus.En && bus.ClrReq) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
        end else begin
          mem_we = bus.En && bus.We && wr_in_range;
          rd_acc = bus.En && bus.Re;
        end
      end
    endcase
  end

  always_comb begin
    collide = (state_q == ST_READY) && mem_we && (bus.WAddr == bus.RAddr);
    if (!rd_in_range) begin
      rd_word = '0;
    end else if ((RD_MODE == 1) && collide) begin
      rd_word = bus.Din;
    end else begin
      rd_word = mem_q[bus.RAddr];
    end
  end

  // The first stage keeps running during a clear so an in-flight read still completes.
  always_comb begin
    s1_vld_d  = rd_acc;
    s1_data_d = rd_acc ? rd_word : s1_data_q;
    if (OUT_REG != 0) begin
      dout_vld_d = s1_vld_q;
      dout_d     = s1_vld_q ? s1_data_q : dout_q;
    end else begin
      dout_vld_d = rd_acc;
      dout_d     = rd_acc ? rd_word : dout_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we && !Rst) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_CLEAR;
      clr_ptr_q  <= '0;
      s1_vld_q   <= 1'b0;
      s1_data_q  <= '0;
      dout_vld_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      s1_vld_q   <= s1_vld_d;
      s1_data_q  <= s1_data_d;
      dout_vld_q <= dout_vld_d;
      dout_q     <= dout_d;
    end
  end

  assign bus.Busy      = (state_q == ST_CLEAR);
  assign bus.Dout      = dout_q;
  assign bus.DoutValid = dout_vld_q;
endmodule
